// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
// Optional feature macro: DEMUX_STREAM_CNT_EN (per-channel drain counters).
package demux_stream_pkg;

    // Number of output channels and width of the channel index.
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // Width of the optional per-channel drain counters.
    localparam int CNT_W = 8;

    // Channel index carried alongside each upstream word.
    typedef logic [SEL_W-1:0] sel_t;

    // Turns a channel index into a one-hot channel mask.
    function automatic logic [N_CH-1:0] sel_onehot(input sel_t sel);
        logic [N_CH-1:0] mask;
        mask = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage : demux_stream_pkg

// File: rtl/demux_out_slot.sv
// One-entry output register slot (data plus full flag) for one channel.
// A write and a drain in the same cycle leave the slot full with the new word.
module demux_out_slot
    import demux_stream_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         full,
    output logic [W-1:0] q
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next slot state: a write always wins, otherwise a drain empties the slot.
    // The data register only changes on a write, so the last word stays visible.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (full_q && rd_ready) begin
            full_d = 1'b0;
        end
    end

    // Slot registers; reset empties the slot and zeroes the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign q    = data_q;

endmodule : demux_out_slot

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry slot per channel.
// Optional feature macro: DEMUX_STREAM_CNT_EN adds cnt0..cnt3 drain counters.
module demux_1_4_stream
    import demux_stream_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    input  logic [1:0]   up_sel,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [3:0]   y_valid,
`ifdef DEMUX_STREAM_CNT_EN
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2,
    output logic [7:0]   cnt3,
`endif
    input  logic [3:0]   y_ready
);

    sel_t            sel;
    logic [N_CH-1:0] slot_full;
    logic [N_CH-1:0] wr_en_vec;
    logic [W-1:0]    slot_q [N_CH];

    assign sel = up_sel;

    // Ready depends only on the addressed slot: free, or draining this cycle.
    always_comb begin
        up_ready = !slot_full[sel] || y_ready[sel];
    end

    // One-hot write enable; only the addressed slot sees an accepted word.
    always_comb begin
        wr_en_vec = '0;
        if (up_valid && up_ready) begin
            wr_en_vec = sel_onehot(sel);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
        demux_out_slot #(
            .W (W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en_vec[gi]),
            .wr_data  (up_data),
            .rd_ready (y_ready[gi]),
            .full     (slot_full[gi]),
            .q        (slot_q[gi])
        );
    end

    assign y_valid = slot_full;
    assign y0      = slot_q[0];
    assign y1      = slot_q[1];
    assign y2      = slot_q[2];
    assign y3      = slot_q[3];

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Each counter advances on a completed drain and wraps naturally at 255.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (slot_full[i] && y_ready[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule : demux_1_4_stream

// File: tb/tb_demux_1_4_stream.sv
// Testbench for demux_1_4_stream: directed scenarios plus random traffic,
// checked against a per-channel queue model of the stream behaviour.
// Optional feature macro: DEMUX_STREAM_CNT_EN (drain counters are checked too).
module tb_demux_1_4_stream;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         up_valid;
   logic         up_ready;
   logic [W-1:0] up_data;
   logic [1:0]   up_sel;
   logic [W-1:0] y0;
   logic [W-1:0] y1;
   logic [W-1:0] y2;
   logic [W-1:0] y3;
   logic [3:0]   y_valid;
   logic [3:0]   y_ready;
`ifdef DEMUX_STREAM_CNT_EN
   logic [7:0]   cnt0;
   logic [7:0]   cnt1;
   logic [7:0]   cnt2;
   logic [7:0]   cnt3;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: words waiting in each channel, the last word each
   // channel was given, the drain counts and the order words left each channel.
   logic [W-1:0] modelQueue [4][$];
   logic [W-1:0] lastWord [4];
   logic [7:0]   drainCount [4];
   logic [W-1:0] recvLog [4][$];

   demux_1_4_stream #(
      .W (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .up_sel   (up_sel),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .y_valid  (y_valid),
`ifdef DEMUX_STREAM_CNT_EN
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .cnt3     (cnt3),
`endif
      .y_ready  (y_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Empties the model as a reset does.
   task automatic clearModel();
      for (int i = 0; i < 4; i++) begin
         modelQueue[i].delete();
         lastWord[i]   = '0;
         drainCount[i] = '0;
      end
   endtask

   function automatic logic [W-1:0] dutY(input int ch);
      case (ch)
         0:       return y0;
         1:       return y1;
         2:       return y2;
         default: return y3;
      endcase
   endfunction

`ifdef DEMUX_STREAM_CNT_EN
   function automatic logic [7:0] dutCnt(input int ch);
      case (ch)
         0:       return cnt0;
         1:       return cnt1;
         2:       return cnt2;
         default: return cnt3;
      endcase
   endfunction
`endif

   // Compares every registered output against the model.
   task automatic checkState(input string tag);
      logic [3:0] expValid;
      expValid = '0;
      for (int i = 0; i < 4; i++) begin
         expValid[i] = (modelQueue[i].size() != 0);
      end
      checkOutput({tag, ".y_valid"}, 32'(y_valid), 32'(expValid));
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s.y%0d", tag, i), 32'(dutY(i)),
                     32'(modelQueue[i].size() != 0 ? modelQueue[i][0] : lastWord[i]));
`ifdef DEMUX_STREAM_CNT_EN
         checkOutput($sformatf("%s.cnt%0d", tag, i), 32'(dutCnt(i)), 32'(drainCount[i]));
`endif
      end
   endtask

   // Drives one cycle of inputs from the falling edge, checks the handshake,
   // advances the model across the rising edge and checks the result.
   task automatic applyStimulus(input string tag, input logic v, input logic [1:0] sel,
                                input logic [W-1:0] data, input logic [3:0] rdy,
                                input bit fullCheck);
      bit   accept;
      bit   drain [4];
      logic expReady;
      up_valid = v;
      up_sel   = sel;
      up_data  = data;
      y_ready  = rdy;
      #1;
      expReady = (modelQueue[sel].size() == 0) || rdy[sel];
      checkOutput({tag, ".up_ready"}, 32'(up_ready), 32'(expReady));
      accept = v && expReady;
      for (int i = 0; i < 4; i++) begin
         drain[i] = (modelQueue[i].size() != 0) && rdy[i];
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (drain[i]) begin
            recvLog[i].push_back(modelQueue[i].pop_front());
            drainCount[i] = drainCount[i] + 8'd1;
         end
         if (accept && (sel == 2'(i))) begin
            modelQueue[i].push_back(data);
            lastWord[i] = data;
         end
      end
      @(negedge clk);
      if (fullCheck) begin
         checkState(tag);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulseReset(input string tag);
      @(negedge clk);
      up_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      clearModel();
      for (int i = 0; i < 4; i++) begin
         recvLog[i].delete();
      end
      checkState(tag);
      checkOutput({tag, ".up_ready"}, 32'(up_ready), 32'd1);
      @(negedge clk);
      checkOutput({tag, ".y_valid_held"}, 32'(y_valid), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] cntBefore;
      rst      = 1'b1;
      up_valid = 1'b0;
      up_data  = '0;
      up_sel   = '0;
      y_ready  = '0;
      clearModel();
      $display("[TB] starting");

      // Reset state while rst is held high.
      repeat (2) @(negedge clk);
      checkState("reset");
      checkOutput("reset.up_ready", 32'(up_ready), 32'd1);
      rst = 1'b0;

      // Single write into channel 2.
      applyStimulus("single", 1'b1, 2'd2, 4'hA, 4'b0000, 1'b1);
      checkOutput("single.y_valid_c", 32'(y_valid), 32'h4);
      checkOutput("single.y2_c", 32'(y2), 32'hA);
      up_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s != 2) begin
            up_sel = 2'(s);
            #1;
            checkOutput($sformatf("single.up_ready_sel%0d", s), 32'(up_ready), 32'd1);
         end
      end

      // Backpressure: channel 2 stalled for five cycles, upstream blocked.
      for (int k = 0; k < 5; k++) begin
         applyStimulus("stall", 1'b1, 2'd2, 4'h7, 4'b0000, 1'b1);
         checkOutput("stall.y2_c", 32'(y2), 32'hA);
      end
      checkOutput("stall.up_ready_c", 32'(up_ready), 32'd0);

      // Changing the select with valid low leaves every slot alone.
      for (int s = 0; s < 4; s++) begin
         applyStimulus("idle_sel", 1'b0, 2'(s), 4'hF, 4'b0000, 1'b1);
      end

      // Simultaneous drain and write on channel 1.
      applyStimulus("fill1", 1'b1, 2'd1, 4'h3, 4'b0000, 1'b1);
      applyStimulus("dw1", 1'b1, 2'd1, 4'h5, 4'b0010, 1'b1);
      checkOutput("dw1.valid1_c", 32'(y_valid[1]), 32'd1);
      checkOutput("dw1.y1_c", 32'(y1), 32'h5);
`ifdef DEMUX_STREAM_CNT_EN
      checkOutput("dw1.cnt1_c", 32'(cnt1), 32'd1);
`endif

      // Drain everything, then round-robin streaming with all consumers ready.
      applyStimulus("drain_all", 1'b0, 2'd0, 4'h0, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         recvLog[i].delete();
      end
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 4; s++) begin
            applyStimulus("rr", 1'b1, 2'(s), 4'(4 * r + s + 1), 4'b1111, 1'b1);
         end
      end
      applyStimulus("rr_tail", 1'b0, 2'd0, 4'h0, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr.count%0d", i), 32'(recvLog[i].size()), 32'd2);
         if (recvLog[i].size() == 2) begin
            checkOutput($sformatf("rr.first%0d", i), 32'(recvLog[i][0]), 32'(i + 1));
            checkOutput($sformatf("rr.second%0d", i), 32'(recvLog[i][1]), 32'(i + 5));
         end
      end

      // Reset in the middle of operation with all four slots full.
      for (int s = 0; s < 4; s++) begin
         applyStimulus("fill_all", 1'b1, 2'(s), 4'(s + 9), 4'b0000, 1'b1);
      end
      checkOutput("fill_all.y_valid_c", 32'(y_valid), 32'hF);
      pulseReset("midreset");

`ifdef DEMUX_STREAM_CNT_EN
      // Counter wrap: exactly 256 drains on channel 3.
      cntBefore = drainCount[3];
      applyStimulus("wrap_fill", 1'b1, 2'd3, 4'h1, 4'b0000, 1'b1);
      for (int k = 0; k < 255; k++) begin
         applyStimulus("wrap", 1'b1, 2'd3, 4'(k), 4'b1000, 1'b0);
      end
      applyStimulus("wrap_last", 1'b0, 2'd3, 4'h0, 4'b1000, 1'b1);
      checkOutput("wrap.cnt3_c", 32'(cnt3), 32'(cntBefore));
      checkOutput("wrap.cnt0_c", 32'(cnt0), 32'd0);
      checkOutput("wrap.cnt1_c", 32'(cnt1), 32'd0);
      checkOutput("wrap.cnt2_c", 32'(cnt2), 32'd0);
`else
      cntBefore = 8'd0;
`endif

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       4'($urandom), 4'($urandom), 1'b1);
      end

      // Second reset after random traffic, then a short burst.
      pulseReset("endreset");
      for (int k = 0; k < 20; k++) begin
         applyStimulus("post", 1'b1, 2'($urandom_range(0, 3)), 4'($urandom),
                       4'($urandom), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule : tb_demux_1_4_stream

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 SHALL have parameter W, default 4: data width per channel, even and at least 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port up_valid, input, 1: upstream word present.
REQ-005 SHALL have port up_ready, output, 1: upstream word accepted this cycle when high together with up_valid.
REQ-006 SHALL have port up_data, input, W: upstream word.
REQ-007 SHALL have port up_sel, input, 2: destination channel index, 0..3.
REQ-008 SHALL have ports y0..y3, output, W each: per-channel output data.
REQ-009 SHALL have port y_valid, output, 4: bit i is high while channel i holds a word.
REQ-010 SHALL have port y_ready, input, 4: bit i means the channel i consumer takes the word this cycle.

Function
REQ-011 SHALL give each channel a one-entry output slot holding data plus a full flag; y_valid[i] is channel i's full flag and yi is its data.
REQ-012 SHALL accept an upstream word when up_valid && up_ready is true, written into slot up_sel at the next edge; latency from acceptance to y_valid is exactly 1 cycle.
REQ-013 SHALL drive up_ready = !full[up_sel] || y_ready[up_sel], combinationally from slot state, y_ready and up_sel only, never from up_valid.
REQ-014 SHALL drain slot i at an edge where y_valid[i] && y_ready[i] is true.
REQ-015 SHALL keep slot i full with the new word when a drain and a write to slot i occur in the same cycle; the new word replaces the old one with no bubble.
REQ-016 SHALL allow writing one slot while any other slots drain in the same cycle, with no interaction between them.
REQ-017 SHALL hold yi stable while y_valid[i] is high and y_ready[i] is low.
REQ-018 SHALL leave yi at its last value after a drain; only y_valid[i] falls.
REQ-019 SHALL not change any slot when up_sel is changed while up_valid is low.
REQ-020 SHALL not reorder words: the words of each channel leave in the order they were accepted.

Reset
REQ-021 SHALL clear all full flags on rst assertion, at any time including mid-transfer; y_valid is 4'b0000 and y0..y3 are all zero.
REQ-022 SHALL, while rst is high, hold y_valid at 4'b0000; up_ready follows REQ-013 (high).
REQ-023 SHALL discard any word in flight when rst is asserted; no partial word survives.

Configuration
REQ-024 SHALL, with DEMUX_STREAM_CNT_EN defined, add ports cnt0..cnt3 (output, 8 each): per-channel counts of completed drains.
REQ-025 SHALL make each counter wrap from 255 to 0 and reset to 0.
REQ-026 SHALL, without DEMUX_STREAM_CNT_EN, have neither the cnt ports nor any counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the following in package demux_stream_pkg:
- constant N_CH = 4
- constant SEL_W = 2
- typedef sel_t for the channel index
REQ-028 SHALL implement each output slot as sub-module demux_out_slot, instantiated four times; the slot has ports clk, rst, wr_en, wr_data, rd_ready, full, q.
REQ-029 SHALL decode up_sel into a one-hot write-enable vector in the top level; slots never see up_sel.

Verification
REQ-030 SHALL cover single write: up_valid=1, up_sel=2, up_data=4'hA, y_ready=0 for one cycle -> next cycle y_valid=4'b0100, y2=4'hA, up_ready=1 for sel 0, 1 and 3.
REQ-031 SHALL cover backpressure: slot 2 full, y_ready[2]=0, up_sel=2, up_valid=1 -> up_ready=0; y2 holds 4'hA for 5 stalled cycles.
REQ-032 SHALL cover a simultaneous drain and write on slot 1 (full with 4'h3, y_ready[1]=1, up_data=4'h5) -> next cycle y_valid[1]=1, y1=4'h5, one drain counted.
REQ-033 SHALL cover round-robin streaming of sel 0,1,2,3 with all y_ready=1 -> one word per cycle; each channel receives its word exactly once, in order.
REQ-034 SHALL cover reset mid-operation: all four slots full, rst pulsed asynchronously between edges -> y_valid=0 immediately, y0..y3=0, and counters 0 if enabled.
REQ-035 SHALL cover counter wrap, with DEMUX_STREAM_CNT_EN: 256 drains on channel 3 -> cnt3 returns to 0 and the other counters are unchanged.
